// File: rtl/vga_line_fetch_if.sv
// Framebuffer read port between the scanline prefetcher and the framebuffer memory.
interface vga_line_fetch_if #(
    parameter int unsigned BPP          = 8,
    parameter int unsigned FB_ADDR_BITS = 20
);
    logic [FB_ADDR_BITS-1:0] fb_rd_addr;
    logic                    fb_rd_en;
    logic [BPP-1:0]          fb_rd_data;

    modport master (output fb_rd_addr, output fb_rd_en, input fb_rd_data);
    modport slave  (input fb_rd_addr, input fb_rd_en, output fb_rd_data);
endinterface

// File: rtl/vga_line_fetch.sv
// Scanline prefetcher: fetches line N+1 into the back half of a ping-pong line
// buffer while line N is shown, swaps halves at end of line, and returns the
// colour for count_h/count_v two cycles later.
module vga_line_fetch #(
    parameter int unsigned BPP          = 8,
    parameter int unsigned LINE_BITS    = 11,
    parameter int unsigned LINE_WIDTH   = 1280,
    parameter int unsigned FB_HEIGHT    = 512,
    parameter int unsigned MAX_H        = 1649,
    parameter int unsigned MAX_V        = 749,
    parameter int unsigned FB_ADDR_BITS = 20,
    parameter int unsigned FB_LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [LINE_BITS-1:0] count_h_i,
    input  logic [LINE_BITS-1:0] count_v_i,
    vga_line_fetch_if.master     fb,
    output logic [BPP-1:0]       color_o,
    output logic                 fetch_busy_o,
    output logic                 underrun_o
);
    localparam int unsigned XW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam logic [XW-1:0]        X_LAST = XW'(LINE_WIDTH - 1);
    localparam logic [XW-1:0]        X_ONE  = XW'(1);
    localparam logic [LINE_BITS-1:0] H_LAST = LINE_BITS'(MAX_H);
    localparam logic [LINE_BITS-1:0] V_LAST = LINE_BITS'(MAX_V);
    localparam logic [LINE_BITS-1:0] V_ONE  = LINE_BITS'(1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                         state_q, state_d;
    logic                           front_q, front_d;
    logic                           front_valid_q, front_valid_d;
    logic                           back_done_q, back_done_d;
    logic                           underrun_q, underrun_d;
    logic [FB_ADDR_BITS-1:0]        base_q, base_d;
    logic [XW-1:0]                  x_q, x_d;
    logic [FB_LATENCY-1:0]          pen_q, pen_d;
    logic [FB_LATENCY-1:0][XW-1:0]  px_q, px_d;
    logic                           qual_q, qual_d;
    logic [BPP-1:0]                 color_q, color_d;
    logic [BPP-1:0]                 rd_q;
    logic [BPP-1:0]                 line_mem [2][LINE_WIDTH];

    logic [LINE_BITS-1:0]           tgt;
    logic                           issue;
    logic                           swap;
    logic                           cap_en;
    logic [XW-1:0]                  cap_x;
    logic                           in_range;
    logic [XW-1:0]                  rd_x;

    // Fetch FSM next state, {en,x} latency pipe, end-of-line swap and output stage 2.
    always_comb begin
        tgt      = (count_v_i == V_LAST) ? '0 : count_v_i + V_ONE;
        swap     = (count_h_i == H_LAST);
        issue    = (state_q == FETCH);
        cap_en   = pen_q[FB_LATENCY-1];
        cap_x    = px_q[FB_LATENCY-1];
        in_range = (32'(count_h_i) < LINE_WIDTH);
        rd_x     = in_range ? XW'(count_h_i) : '0;

        state_d       = state_q;
        front_d       = front_q;
        front_valid_d = front_valid_q;
        back_done_d   = back_done_q;
        underrun_d    = underrun_q;
        base_d        = base_q;
        x_d           = x_q;
        pen_d[0]      = issue;
        px_d[0]       = x_q;
        for (int i = 1; i < FB_LATENCY; i++) begin
            pen_d[i] = pen_q[i-1];
            px_d[i]  = px_q[i-1];
        end

        case (state_q)
            IDLE: begin
                if (count_h_i == '0 && 32'(tgt) < FB_HEIGHT) begin
                    state_d = FETCH;
                    base_d  = FB_ADDR_BITS'(32'(tgt) * LINE_WIDTH);
                    x_d     = '0;
                end
            end
            FETCH: begin
                x_d = x_q + X_ONE;
                if (x_q == X_LAST) state_d = DRAIN;
            end
            DRAIN: begin
                if (pen_q == '0) begin
                    back_done_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // The swap overrides a same-cycle drain completion: that line counts as incomplete.
        if (swap) begin
            front_d       = ~front_q;
            front_valid_d = back_done_q;
            back_done_d   = 1'b0;
            if (state_q != IDLE) begin
                underrun_d    = 1'b1;
                state_d       = IDLE;
                pen_d         = '0;
                front_valid_d = 1'b0;
            end
        end

        qual_d  = front_valid_q && in_range;
        color_d = qual_q ? rd_q : '0;
    end

    // Control state, latency pipe and the colour output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            front_q       <= 1'b0;
            front_valid_q <= 1'b0;
            back_done_q   <= 1'b0;
            underrun_q    <= 1'b0;
            base_q        <= '0;
            x_q           <= '0;
            pen_q         <= '0;
            px_q          <= '0;
            qual_q        <= 1'b0;
            color_q       <= '0;
        end else begin
            state_q       <= state_d;
            front_q       <= front_d;
            front_valid_q <= front_valid_d;
            back_done_q   <= back_done_d;
            underrun_q    <= underrun_d;
            base_q        <= base_d;
            x_q           <= x_d;
            pen_q         <= pen_d;
            px_q          <= px_d;
            qual_q        <= qual_d;
            color_q       <= color_d;
        end
    end

    // Line buffer: capture returning pixels into the back half, registered read of the front half.
    always_ff @(posedge clk) begin
        if (cap_en) line_mem[~front_q][cap_x] <= fb.fb_rd_data;
        rd_q <= line_mem[front_q][rd_x];
    end

    assign fb.fb_rd_en   = issue;
    assign fb.fb_rd_addr = issue ? base_q + FB_ADDR_BITS'(x_q) : '0;
    assign color_o       = color_q;
    assign fetch_busy_o  = (state_q != IDLE);
    assign underrun_o    = underrun_q;
endmodule

// File: tb/tb_vga_line_fetch.sv
// Bench for vga_line_fetch with a shrunken raster (24 visible pixels, 36-pixel
// lines, 20-line frames, 12-line framebuffer). The framebuffer returns the low
// byte of each address; a line-level model predicts every output each cycle.
module tb_vga_line_fetch;
    localparam int BPP = 8;
    localparam int LB  = 11;
    localparam int LW  = 24;
    localparam int FBH = 12;
    localparam int MH  = 35;
    localparam int MV  = 19;
    localparam int AW  = 20;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [LB-1:0] count_h = '0;
    logic [LB-1:0] count_v = '0;
    logic [BPP-1:0] color;
    logic          busy;
    logic          underrun;

    vga_line_fetch_if #(.BPP(BPP), .FB_ADDR_BITS(AW)) fb_if ();

    vga_line_fetch #(
        .BPP(BPP), .LINE_BITS(LB), .LINE_WIDTH(LW), .FB_HEIGHT(FBH),
        .MAX_H(MH), .MAX_V(MV), .FB_ADDR_BITS(AW), .FB_LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset), .count_h_i(count_h), .count_v_i(count_v),
        .fb(fb_if), .color_o(color), .fetch_busy_o(busy), .underrun_o(underrun)
    );

    always #5 clk = ~clk;

    // Framebuffer memory: pixel at address a is a[7:0], returned LAT cycles after the strobe.
    logic [LAT-1:0]         rsp_en = '0;
    logic [LAT-1:0][AW-1:0] rsp_addr = '0;
    always @(posedge clk) begin
        rsp_en   <= {rsp_en[LAT-2:0], fb_if.fb_rd_en};
        rsp_addr <= {rsp_addr[LAT-2:0], fb_if.fb_rd_addr};
    end
    assign fb_if.fb_rd_data = rsp_en[LAT-1] ? rsp_addr[LAT-1][7:0] : 8'hA5;

    int n_tests = 0;
    int n_fail  = 0;
    int phase   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (line %0d, h %0d, t=%0t)",
                     nm, act, exp, count_v, count_h, $time);
        end
    endtask

    // Line-level model: a fetch of line tgt starts at h==0, streams LW reads,
    // then needs LAT+1 further cycles to land; an end-of-line swap promotes it
    // only if it landed, otherwise the fetch is abandoned and flagged.
    bit       m_started = 0, m_rst_last = 0;
    bit       m_fetch = 0, m_back_ok = 0, m_front_ok = 0, m_under = 0;
    int       m_k = 0, m_back_line = 0, m_front_line = 0;
    logic [7:0] m_c1 = '0, m_c2 = '0;

    always @(posedge clk) begin
        int h, v, tgt;
        h   = int'(count_h);
        v   = int'(count_v);
        tgt = (v == MV) ? 0 : v + 1;
        m_rst_last <= reset;
        if (reset) begin
            m_started  <= 1;
            m_fetch    <= 0;
            m_back_ok  <= 0;
            m_front_ok <= 0;
            m_under    <= 0;
            m_k        <= 0;
            m_c1       <= '0;
            m_c2       <= '0;
        end else begin
            m_c1 <= (m_front_ok && h < LW) ? 8'(m_front_line * LW + h) : 8'h00;
            m_c2 <= m_c1;
            if (h == MH) begin
                m_front_line <= m_back_line;
                m_front_ok   <= m_back_ok && !m_fetch;
                m_back_ok    <= 0;
                if (m_fetch) begin
                    m_under <= 1;
                    m_fetch <= 0;
                end
            end else if (m_fetch) begin
                if (m_k == LW + LAT) begin
                    m_fetch   <= 0;
                    m_back_ok <= 1;
                end else begin
                    m_k <= m_k + 1;
                end
            end else if (h == 0 && tgt < FBH) begin
                m_fetch     <= 1;
                m_k         <= 0;
                m_back_line <= tgt;
            end
        end
    end

    // Per-cycle comparison against the model, plus hand-computed literal points.
    always @(negedge clk) begin
        if (m_started) begin
            bit exp_en;
            exp_en = m_fetch && (m_k < LW);
            chk("rd_en", int'(fb_if.fb_rd_en), int'(exp_en));
            if (exp_en) chk("rd_addr", int'(fb_if.fb_rd_addr), m_back_line * LW + m_k);
            chk("color", int'(color), int'(m_c2));
            chk("busy", int'(busy), int'(m_fetch));
            chk("underrun", int'(underrun), int'(m_under));

            if (m_rst_last) begin
                chk("lit_reset_color", int'(color), 0);
                chk("lit_reset_en", int'(fb_if.fb_rd_en), 0);
                chk("lit_reset_addr", int'(fb_if.fb_rd_addr), 0);
                chk("lit_reset_underrun", int'(underrun), 0);
            end
            if (phase == 1) begin
                if (count_v == 0 && count_h == 10) chk("lit_first_line_blank", int'(color), 0);
                if (count_v == 3 && count_h == 1)  chk("lit_l3_addr_first", int'(fb_if.fb_rd_addr), 96);
                if (count_v == 3 && count_h == 24) chk("lit_l3_addr_last", int'(fb_if.fb_rd_addr), 119);
                if (count_v == 4 && count_h == 2)  chk("lit_l4_color_k0", int'(color), 96);
                if (count_v == 4 && count_h == 25) chk("lit_l4_color_k23", int'(color), 119);
                if (count_v == 4 && count_h == 30) chk("lit_l4_color_blank", int'(color), 0);
                if (count_v == 11 && count_h == 2) chk("lit_l11_color_wrap", int'(color), 8);
                if (count_v == 11 && count_h == 25) chk("lit_l11_color_last", int'(color), 31);
                if (count_v == 11 && count_h == 5) chk("lit_l11_no_fetch", int'(busy), 0);
                if (count_v == 15 && count_h == 10) chk("lit_l15_blank", int'(color), 0);
            end
            if (phase == 2 && count_v == 0 && count_h == 25) chk("lit_f2_l0_color", int'(color), 23);
            if (phase == 3) begin
                if (count_v == 3 && count_h == 0)  chk("lit_underrun_set", int'(underrun), 1);
                if (count_v == 3 && count_h == 10) chk("lit_underrun_blank", int'(color), 0);
                if (count_v == 4 && count_h == 10) chk("lit_after_underrun", int'(color), 104);
                if (count_v == 5 && count_h == 0)  chk("lit_underrun_sticky", int'(underrun), 1);
            end
            if (phase == 4) begin
                if (count_v == 6 && count_h == 12) begin
                    chk("lit_rst_en", int'(fb_if.fb_rd_en), 0);
                    chk("lit_rst_color", int'(color), 0);
                    chk("lit_rst_underrun", int'(underrun), 0);
                end
                if (count_v == 7 && count_h == 1)  chk("lit_refetch_addr", int'(fb_if.fb_rd_addr), 192);
                if (count_v == 7 && count_h == 10) chk("lit_l7_blank", int'(color), 0);
                if (count_v == 8 && count_h == 10) chk("lit_l8_color", int'(color), 200);
            end
        end
    end

    task automatic drive(input int h, input int v, input bit r);
        @(posedge clk);
        #1;
        count_h = LB'(h);
        count_v = LB'(v);
        reset   = r;
    endtask

    task automatic run_line(input int v, input int h_first, input int h_last);
        for (int h = h_first; h <= h_last; h++) drive(h, v, 1'b0);
    endtask

    initial begin
        repeat (3) drive(0, 0, 1'b1);

        phase = 1;
        for (int v = 0; v <= MV; v++) run_line(v, 0, MH);

        phase = 2;
        for (int v = 0; v <= MV; v++) run_line(v, 0, MH);

        phase = 3;
        run_line(0, 0, MH);
        run_line(1, 0, MH);
        run_line(2, 0, 5);
        drive(MH, 2, 1'b0);
        for (int v = 3; v <= 5; v++) run_line(v, 0, MH);

        phase = 4;
        run_line(6, 0, 10);
        drive(11, 6, 1'b1);
        run_line(6, 12, MH);
        for (int v = 7; v <= 9; v++) run_line(v, 0, MH);

        @(posedge clk);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
